// File: rtl/dram_snapshot_writer_pkg.sv
// Shared types and widths for the DRAM snapshot writer.
package dram_snapshot_writer_pkg;

    localparam int DATA_W = 144;
    localparam int BE_W   = 18;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_BEAT0   = 3'd3,
        ST_BEAT1   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/dram_snapshot_writer_fifo.sv
// First-word-fall-through sample buffer; the head word is held in a register so
// the DRAM write data leaves the block straight from a flop.
module snapshot_fifo
    import dram_snapshot_writer_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [AW-1:0]     rd_next_idx;
    logic              push_ok;
    logic              pop_ok;

    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok      = pop_i && !empty_o;
    // A push into a full buffer is still taken when the head leaves the same cycle.
    assign push_ok     = push_i && (!full_o || pop_ok);
    assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign dout_o      = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        dout_d   = dout_q;
        if (pop_ok) begin
            if (count_o > (AW+1)'(1)) begin
                dout_d = mem_q[rd_next_idx];
            end else if (push_ok) begin
                dout_d = din_i;
            end
        end else if (empty_o && push_ok) begin
            dout_d = din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/dram_snapshot_writer.sv
// Capture engine: buffers 144-bit samples and issues them as two-beat DRAM write bursts.
//
// state   | meaning
// IDLE    | waiting for a ctrl_start rising edge
// ARMED   | region reset, waiting for trig
// CAPTURE | buffering samples until a full burst (2 words) is available
// BEAT0   | first beat of a burst on the request bus
// BEAT1   | second beat, same address
// DRAIN   | discarding leftover buffered words
// DONE    | one cycle before returning to IDLE
module dram_snapshot_writer
    import dram_snapshot_writer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0,
    parameter logic [ADDR_W-1:0] ADDR_STEP  = 32'd8,
    parameter logic [31:0]       NUM_BURSTS = 32'd1024,
    parameter int                FIFO_AW    = 4
) (
    input  logic              Mem_Clk,
    input  logic              Mem_Rst_n,
    input  logic              ctrl_start,
    input  logic              ctrl_ring,
    input  logic              ctrl_stop,
    input  logic              trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_overflow,
    output logic [ADDR_W-1:0] status_addr,
    output logic [ADDR_W-1:0] Mem_Cmd_Address,
    output logic              Mem_Cmd_RNW,
    output logic              Mem_Cmd_Valid,
    output logic [31:0]       Mem_Cmd_Tag,
    input  logic              Mem_Cmd_Ack,
    output logic [DATA_W-1:0] Mem_Wr_Din,
    output logic [BE_W-1:0]   Mem_Wr_BE
);

    state_e            state_q, state_d;
    logic              start_q;
    logic              ring_q, ring_d;
    logic              stop_pend_q, stop_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic              start_rise;
    logic              burst_last;
    logic              stop_req;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [DATA_W-1:0] fifo_dout;

    snapshot_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (Mem_Clk),
        .rst_ni  (Mem_Rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign start_rise = ctrl_start && !start_q;
    assign burst_last = ((cnt_q + 32'd1) == NUM_BURSTS);
    assign stop_req   = ctrl_stop || stop_pend_q;
    // The trig cycle itself already carries a sample.
    assign fifo_push  = din_valid &&
                        ((state_q == ST_CAPTURE) || (state_q == ST_BEAT0) ||
                         (state_q == ST_BEAT1)   || ((state_q == ST_ARMED) && trig));

    always_comb begin
        state_d     = state_q;
        ring_d      = ring_q;
        stop_pend_d = stop_pend_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d     = ST_ARMED;
                    done_d      = 1'b0;
                    ovf_d       = 1'b0;
                    addr_d      = BASE_ADDR;
                    cnt_d       = '0;
                    ring_d      = ctrl_ring;
                    stop_pend_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (stop_req) begin
                    state_d = ST_DRAIN;
                end else if (fifo_count >= (FIFO_AW+1)'(2)) begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (ctrl_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (Mem_Cmd_Ack) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (ctrl_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (Mem_Cmd_Ack) begin
                    fifo_pop = 1'b1;
                    addr_d   = addr_q + ADDR_STEP;
                    cnt_d    = cnt_q + 32'd1;
                    if (burst_last && !ring_q) begin
                        state_d = ST_DRAIN;
                    end else if (burst_last) begin
                        addr_d  = BASE_ADDR;
                        cnt_d   = '0;
                        state_d = ST_CAPTURE;
                    end else if (stop_req) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_DRAIN: begin
                stop_pend_d = 1'b0;
                if (fifo_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end

        valid_d = (state_d == ST_BEAT0) || (state_d == ST_BEAT1);
    end

    always_ff @(posedge Mem_Clk) begin
        if (!Mem_Rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            ring_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            addr_q      <= BASE_ADDR;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= ctrl_start;
            ring_q      <= ring_d;
            stop_pend_q <= stop_pend_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
        end
    end

    assign status_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign status_done     = done_q;
    assign status_overflow = ovf_q;
    assign status_addr     = addr_q;

    assign Mem_Cmd_Address = addr_q;
    assign Mem_Cmd_RNW     = 1'b0;
    assign Mem_Cmd_Valid   = valid_q;
    assign Mem_Cmd_Tag     = '0;
    assign Mem_Wr_Din      = fifo_dout;
    assign Mem_Wr_BE       = {BE_W{valid_q}};

endmodule

// File: tb/tb_dram_snapshot_writer.sv
// Randomized self-checking bench for dram_snapshot_writer against a queue-based model.
module tb_dram_snapshot_writer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] STEP = 32'd8;
    localparam int          NB   = 4;
    localparam int          DEP  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ctrl_start, ctrl_ring, ctrl_stop, trig;
    logic [143:0] din;
    logic         din_valid;
    logic         busy, done, ovf;
    logic [31:0]  saddr, caddr, tag;
    logic         rnw, valid, ack;
    logic [143:0] wdata;
    logic [17:0]  be;

    int total = 0;
    int bad   = 0;
    bit ack_rand = 0;

    logic [143:0] sent[$];
    logic [31:0]  obs_addr[$];
    logic [143:0] obs_data[$];

    always #5 clk = ~clk;

    dram_snapshot_writer #(
        .BASE_ADDR  (BASE),
        .ADDR_STEP  (STEP),
        .NUM_BURSTS (NB),
        .FIFO_AW    (4)
    ) dut (
        .Mem_Clk         (clk),
        .Mem_Rst_n       (rst_n),
        .ctrl_start      (ctrl_start),
        .ctrl_ring       (ctrl_ring),
        .ctrl_stop       (ctrl_stop),
        .trig            (trig),
        .din             (din),
        .din_valid       (din_valid),
        .status_busy     (busy),
        .status_done     (done),
        .status_overflow (ovf),
        .status_addr     (saddr),
        .Mem_Cmd_Address (caddr),
        .Mem_Cmd_RNW     (rnw),
        .Mem_Cmd_Valid   (valid),
        .Mem_Cmd_Tag     (tag),
        .Mem_Cmd_Ack     (ack),
        .Mem_Wr_Din      (wdata),
        .Mem_Wr_BE       (be)
    );

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Beats are recorded mid-cycle, ahead of the edge that accepts them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                chk("be_on", 160'(be), 160'(18'h3ffff));
                chk("rnw_tag", 160'({rnw, tag}), 160'(0));
                if (ack) begin
                    obs_addr.push_back(caddr);
                    obs_data.push_back(wdata);
                end
            end else begin
                chk("be_off", 160'(be), 160'(0));
            end
        end
    end

    function automatic logic [143:0] rand_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[143:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (ack_rand) ack = ($urandom_range(3) != 0);
    endtask

    task automatic drive_word(input bit v);
        din_valid = v;
        if (v) begin
            din = rand_word();
            sent.push_back(din);
        end
    endtask

    task automatic arm(input bit ring);
        cyc();
        cyc();
        sent.delete();
        obs_addr.delete();
        obs_data.delete();
        ctrl_ring  = ring;
        ctrl_start = 1'b1;
        cyc();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            cyc();
            n++;
        end
        chk({name, "_done"}, 160'(done), 160'(1));
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!valid && n < limit) begin
            cyc();
            n++;
        end
        chk({name, "_valid"}, 160'(valid), 160'(1));
    endtask

    // Model: beat i carries the i-th captured word; burst i/2 lands at BASE + STEP*((i/2) mod NB).
    task automatic check_beats(input string name, input int n_exp);
        logic [31:0] ea;
        chk({name, "_nbeats"}, 160'(obs_addr.size()), 160'(n_exp));
        for (int i = 0; i < obs_addr.size() && i < n_exp; i++) begin
            ea = BASE + STEP * 32'((i / 2) % NB);
            chk({name, "_addr"}, 160'(obs_addr[i]), 160'(ea));
            if (i < sent.size()) chk({name, "_data"}, 160'(obs_data[i]), 160'(sent[i]));
        end
    endtask

    task automatic run_oneshot(input string name);
        int k = 0;
        int first_v = -1;
        ack = 1'b1;
        arm(1'b0);
        trig = 1'b1;
        while (!done && k < 200) begin
            if (valid && first_v < 0) first_v = k;
            drive_word(1'b1);
            cyc();
            trig = 1'b0;
            k++;
        end
        din_valid = 1'b0;
        chk({name, "_done"}, 160'(done), 160'(1));
        chk({name, "_lat"}, 160'(first_v), 160'(3));
        check_beats(name, 2 * NB);
        chk({name, "_busy"}, 160'(busy), 160'(0));
        chk({name, "_saddr"}, 160'(saddr), 160'(BASE + STEP * NB));
        chk({name, "_ovf"}, 160'(ovf), 160'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_exp;
        rst_n = 1'b0; ctrl_start = 1'b0; ctrl_ring = 1'b0; ctrl_stop = 1'b0;
        trig = 1'b0; din = '0; din_valid = 1'b0; ack = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 160'(valid), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_done", 160'(done), 160'(0));
        chk("rst_ovf", 160'(ovf), 160'(0));
        chk("rst_saddr", 160'(saddr), 160'(BASE));
        rst_n = 1'b1;
        cyc();

        // One-shot, continuous samples, Ack always high.
        run_oneshot("oneshot");

        // Stall in BEAT1, then odd word count ended by stop.
        ack = 1'b0;
        arm(1'b0);
        trig = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_word(1'b1);
            cyc();
            trig = 1'b0;
        end
        din_valid = 1'b0;
        wait_valid("stall", 20);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_v", 160'(valid), 160'(1));
            chk("stall_addr", 160'(caddr), 160'(BASE));
            chk("stall_data", 160'(wdata), 160'(sent[1]));
            cyc();
        end
        ack = 1'b1;
        repeat (12) cyc();
        ctrl_stop = 1'b1;
        wait_done("odd", 50);
        ctrl_stop = 1'b0;
        check_beats("odd", 4);
        chk("odd_ovf", 160'(ovf), 160'(0));
        chk("odd_saddr", 160'(saddr), 160'(BASE + 2 * STEP));
        chk("odd_valid", 160'(valid), 160'(0));

        // Overflow: 20 samples while the bridge refuses, in ring mode.
        ack = 1'b0;
        arm(1'b1);
        trig = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_word(1'b1);
            cyc();
            trig = 1'b0;
        end
        din_valid = 1'b0;
        chk("ovf_flag", 160'(ovf), 160'(1));
        ack = 1'b1;
        n = 0;
        while (obs_addr.size() < DEP && n < 200) begin
            cyc();
            n++;
        end
        repeat (10) cyc();
        chk("ovf_idle_valid", 160'(valid), 160'(0));
        ctrl_stop = 1'b1;
        wait_done("ovf", 50);
        ctrl_stop = 1'b0;
        check_beats("ovf", DEP);
        chk("ovf_sticky", 160'(ovf), 160'(1));
        chk("ovf_saddr", 160'(saddr), 160'(BASE));

        // Ring mode with random traffic and Ack; stop raised during a BEAT0.
        ack_rand = 1'b1;
        arm(1'b1);
        trig = 1'b1;
        n = 0;
        while ((obs_addr.size() < 12 || !(valid && (obs_addr.size() % 2 == 0))) && n < 2000) begin
            drive_word($urandom_range(2) == 0);
            cyc();
            trig = 1'b0;
            n++;
        end
        chk("ring_reach", 160'(n < 2000), 160'(1));
        n_exp = obs_addr.size() + 2;
        ctrl_stop = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            drive_word($urandom_range(2) == 0);
            cyc();
            n++;
        end
        din_valid = 1'b0;
        ctrl_stop = 1'b0;
        ack_rand = 1'b0;
        ack = 1'b1;
        chk("ring_done", 160'(done), 160'(1));
        check_beats("ring", n_exp);
        chk("ring_ovf", 160'(ovf), 160'(0));
        chk("ring_saddr", 160'(saddr), 160'(BASE + STEP * 32'((n_exp / 2) % NB)));

        // Reset while in BEAT1, then a normal run.
        ack = 1'b0;
        arm(1'b0);
        trig = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_word(1'b1);
            cyc();
            trig = 1'b0;
        end
        din_valid = 1'b0;
        wait_valid("rb", 20);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("rb_beat1", 160'(valid), 160'(1));
        rst_n = 1'b0;
        cyc();
        chk("rb_valid", 160'(valid), 160'(0));
        chk("rb_busy", 160'(busy), 160'(0));
        chk("rb_saddr", 160'(saddr), 160'(BASE));
        chk("rb_done", 160'(done), 160'(0));
        rst_n = 1'b1;
        ack = 1'b1;
        repeat (5) cyc();
        chk("rb_nbeats", 160'(obs_addr.size()), 160'(1));
        run_oneshot("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
